enet_gmii_tx_sched: RTL and testbench

Transmit scheduler that shares the GMII transmit interface of the RGMII/GMII bridge between two byte-stream requesters. It sits in the `gmii_tx_clk` domain directly in front of the bridge's `gmii_tx_en` / `gmii_tx_er` / `gmii_txd` inputs. It arbitrates with fixed priority between a control-frame source (pause/management) and the normal data-frame source. For each frame it prepends preamble and SFD, enforces the inter-frame gap, and signals underruns on `gmii_tx_er`. Frame payloads arrive with FCS already appended upstream.

---
 rtl/enet_gmii_tx_sched.sv | 114 +++++++++++
 tb/tb_enet_gmii_tx_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/enet_gmii_tx_sched.sv
// enet_gmii_tx_sched: fixed-priority two-source GMII transmit scheduler.
// It adds preamble and SFD, enforces the inter-frame gap and flags underruns on tx_er.
module enet_gmii_tx_sched #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic        s0_tlast,
  input  logic [7:0]  s0_tdata,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic        s1_tlast,
  input  logic [7:0]  s1_tdata,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [7:0]  gmii_txd,
  output logic        busy,
  output logic        grant_src,
  output logic [15:0] tx_frames,
  output logic [15:0] tx_underruns
);
  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_DRAIN, ST_IFG} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        en_q, er_q, grant_q;
  logic [7:0]  txd_q;
  logic [15:0] frames_q, underruns_q;
  logic        sel_valid, sel_last, xfer;
  logic [7:0]  sel_data;
  assign sel_valid = grant_q ? s1_tvalid : s0_tvalid;
  assign sel_last  = grant_q ? s1_tlast  : s0_tlast;
  assign sel_data  = grant_q ? s1_tdata  : s0_tdata;
  assign xfer      = (state_q == ST_DATA) || (state_q == ST_DRAIN);
  assign s0_tready = xfer && !grant_q;
  assign s1_tready = xfer && grant_q;
  assign busy         = state_q != ST_IDLE;
  assign gmii_tx_en   = en_q;
  assign gmii_tx_er   = er_q;
  assign gmii_txd     = txd_q;
  assign grant_src    = grant_q;
  assign tx_frames    = frames_q;
  assign tx_underruns = underruns_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      er_q        <= 1'b0;
      txd_q       <= '0;
      grant_q     <= 1'b0;
      frames_q    <= '0;
      underruns_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          en_q  <= 1'b0;
          er_q  <= 1'b0;
          txd_q <= '0;
          if (tx_enable && (s0_tvalid || s1_tvalid)) begin
            grant_q <= !s0_tvalid;
            cnt_q   <= 5'(PREAMBLE_BYTES - 1);
            state_q <= ST_PRE;
          end
        end
        ST_PRE: begin
          en_q  <= 1'b1;
          er_q  <= 1'b0;
          txd_q <= 8'h55;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= ST_SFD;
        end
        ST_SFD: begin
          en_q    <= 1'b1;
          txd_q   <= 8'hD5;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          en_q  <= 1'b1;
          er_q  <= !sel_valid;
          txd_q <= sel_valid ? sel_data : 8'h00;
          if (!sel_valid) begin
            underruns_q <= underruns_q + 16'd1;
            state_q     <= ST_DRAIN;
          end else if (sel_last) begin
            frames_q <= frames_q + 16'd1;
            cnt_q    <= 5'(IFG_BYTES - 2);
            state_q  <= ST_IFG;
          end
        end
        ST_DRAIN: begin
          en_q  <= 1'b0;
          er_q  <= 1'b0;
          txd_q <= '0;
          if (sel_valid && sel_last) begin
            cnt_q   <= 5'(IFG_BYTES - 2);
            state_q <= ST_IFG;
          end
        end
        ST_IFG: begin
          en_q  <= 1'b0;
          er_q  <= 1'b0;
          txd_q <= '0;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enet_gmii_tx_sched.sv
// tb_enet_gmii_tx_sched: directed checks of framing, arbitration, IFG, underrun, gating and reset.
module tb_enet_gmii_tx_sched;
  logic clk = 1'b0, rst_n = 1'b0, tx_enable = 1'b0;
  logic s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
  logic [7:0] s0_tdata = '0, s1_tdata = '0;
  logic s0_tready, s1_tready, gmii_tx_en, gmii_tx_er, busy, grant_src;
  logic [7:0] gmii_txd;
  logic [15:0] tx_frames, tx_underruns;
  int cmp = 0, errs = 0, to_cnt = 0, bad_rdy = 0;
  bit en_l[$], er_l[$];
  logic [7:0] d_l[$];

  enet_gmii_tx_sched dut (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd),
    .busy(busy), .grant_src(grant_src), .tx_frames(tx_frames), .tx_underruns(tx_underruns));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    en_l.push_back(gmii_tx_en);
    er_l.push_back(gmii_tx_er);
    d_l.push_back(gmii_txd);
    if (busy && !grant_src && s1_tready) bad_rdy++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit src, input bit v, input logic [7:0] d, input bit l);
    if (src) begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
    else begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
  endtask

  task automatic send(input bit src, input int n, input int base, input int hole_at, input int hole_len);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      if (i == hole_at) begin
        drv(src, 1'b0, 8'h00, 1'b0);
        repeat (hole_len) tick();
      end
      drv(src, 1'b1, 8'(base + i), i == n - 1);
      while (!(src ? s1_tready : s0_tready) && w < 300) begin tick(); w++; end
      if (w >= 300) begin to_cnt++; break; end
      tick();
    end
    drv(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 500) begin tick(); w++; end
    if (w >= 500) to_cnt++;
    tick();
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int first_en(int from);
    for (int i = from; i < en_l.size(); i++) if (en_l[i]) return i;
    return -1000;
  endfunction

  function automatic int run(int from, bit v);
    int n = 0;
    if (from < 0) return -1;
    while (from + n < en_l.size() && en_l[from + n] == v) n++;
    return n;
  endfunction

  function automatic logic [7:0] dat(int i);
    return (i >= 0 && i < d_l.size()) ? d_l[i] : 8'hxx;
  endfunction

  function automatic bit hdr_ok(int s);
    for (int k = 0; k < 7; k++) if (dat(s + k) !== 8'h55) return 1'b0;
    return dat(s + 7) === 8'hD5;
  endfunction

  function automatic int payload_bad(int s, int n, int base);
    int b = 0;
    for (int i = 0; i < n; i++) if (dat(s + 8 + i) !== 8'(base + i)) b++;
    return b;
  endfunction

  function automatic int count(int from, bit er);
    int c = 0;
    for (int i = from; i < en_l.size(); i++) c += er ? int'(er_l[i]) : int'(en_l[i]);
    return c;
  endfunction

  initial begin
    int m, s, g, r0;
    bit seen;
    do_reset();
    tx_enable = 1'b1;
    chk("reset_outputs", {gmii_tx_en, gmii_tx_er, gmii_txd, busy, grant_src, s0_tready, s1_tready}, 0);
    chk("reset_counters", {tx_frames, tx_underruns}, 0);

    // single 64-byte s1 frame
    m = en_l.size();
    send(1'b1, 64, 8'h10, -1, 0);
    wait_idle();
    s = first_en(m);
    chk("t1_header", hdr_ok(s), 1);
    chk("t1_en_len", run(s, 1'b1), 72);
    chk("t1_payload_bad", payload_bad(s, 64, 8'h10), 0);
    chk("t1_er_count", count(m, 1'b1), 0);
    chk("t1_frames", tx_frames, 1);
    chk("t1_grant_src", grant_src, 1);

    // simultaneous s0/s1 requests
    do_reset();
    m = en_l.size();
    r0 = bad_rdy;
    fork
      send(1'b0, 8, 8'hA0, -1, 0);
      send(1'b1, 16, 8'h30, -1, 0);
    join
    wait_idle();
    s = first_en(m);
    chk("t2_first_len", run(s, 1'b1), 16);
    chk("t2_first_payload_bad", payload_bad(s, 8, 8'hA0), 0);
    g = s + 16;
    chk("t2_gap", run(g, 1'b0), 12);
    chk("t2_second_header", hdr_ok(g + 12), 1);
    chk("t2_second_len", run(g + 12, 1'b1), 24);
    chk("t2_second_payload_bad", payload_bad(g + 12, 16, 8'h30), 0);
    chk("t2_s1_ready_in_s0", bad_rdy - r0, 0);
    chk("t2_frames", tx_frames, 2);

    // back-to-back s1 frames
    do_reset();
    m = en_l.size();
    send(1'b1, 10, 8'h60, -1, 0);
    send(1'b1, 10, 8'h80, -1, 0);
    wait_idle();
    s = first_en(m);
    chk("t3_first_len", run(s, 1'b1), 18);
    chk("t3_gap", run(s + 18, 1'b0), 12);
    chk("t3_second_payload_bad", payload_bad(s + 30, 10, 8'h80), 0);
    chk("t3_frames", tx_frames, 2);

    // underrun after byte 5 of a 20-byte frame
    do_reset();
    m = en_l.size();
    send(1'b1, 20, 8'h40, 5, 3);
    wait_idle();
    s = first_en(m);
    chk("t4_en_len", run(s, 1'b1), 14);
    chk("t4_payload_bad", payload_bad(s, 5, 8'h40), 0);
    chk("t4_err_slot", {er_l[s + 13], dat(s + 13)}, 9'h100);
    chk("t4_er_count", count(m, 1'b1), 1);
    chk("t4_en_count", count(m, 1'b0), 14);
    chk("t4_underruns", tx_underruns, 1);
    chk("t4_frames", tx_frames, 0);

    // tx_enable gating
    do_reset();
    tx_enable = 1'b0;
    drv(1'b1, 1'b1, 8'h99, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen |= busy | gmii_tx_en;
    end
    chk("t5_no_grant", seen, 0);
    tx_enable = 1'b1;
    tick();
    chk("t5_en_after_1", {busy, gmii_tx_en}, 2'b10);
    tick();
    chk("t5_en_after_2", gmii_tx_en, 1);

    // reset in the middle of DATA
    do_reset();
    drv(1'b1, 1'b1, 8'h77, 1'b0);
    g = 0;
    while (!s1_tready && g < 50) begin tick(); g++; end
    if (g >= 50) to_cnt++;
    tick();
    tick();
    chk("t6_pre_reset_active", {gmii_tx_en, grant_src, gmii_txd}, 10'h377);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outputs", {gmii_tx_en, gmii_tx_er, gmii_txd, busy, grant_src, s0_tready, s1_tready}, 0);
    chk("t6_async_counters", {tx_frames, tx_underruns}, 0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    m = en_l.size();
    send(1'b0, 4, 8'hC0, -1, 0);
    wait_idle();
    s = first_en(m);
    chk("t6_header", hdr_ok(s), 1);
    chk("t6_payload_bad", payload_bad(s, 4, 8'hC0), 0);
    chk("t6_len", run(s, 1'b1), 12);
    chk("t6_frames_grant", {tx_frames, grant_src}, 17'h2);

    chk("handshake_timeouts", to_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
